// File: rtl/dnn_mem_pkg.sv
// Shared memory-system types for the DNN accelerator: arbiter states and bus widths.
package dnn_mem_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

endpackage

// File: rtl/owner_fifo.sv
// Synchronous FIFO recording which requester owns each outstanding read.
module owner_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A push at full is accepted when the same cycle frees a slot.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdram_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM port; routes read returns via an owner FIFO.
module sdram_master_arbiter
  import dnn_mem_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_PENDING = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]             m_read,
  input  logic [NUM_MASTERS-1:0]             m_write,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_writedata,
  output logic [NUM_MASTERS-1:0]             m_waitrequest,
  output logic [DATA_W-1:0]                  m_readdata,
  output logic [NUM_MASTERS-1:0]             m_readdatavalid,
  input  logic                               sdram_waitrequest,
  output logic [ADDR_W-1:0]                  sdram_address,
  output logic                               sdram_read,
  output logic                               sdram_write,
  output logic [DATA_W-1:0]                  sdram_writedata,
  input  logic [DATA_W-1:0]                  sdram_readdata,
  input  logic                               sdram_readdatavalid,
  output logic                               err_orphan
);

  localparam int GW    = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_PENDING) + 1;

  arb_state_t       state;
  logic [GW-1:0]    grant;
  logic [GW-1:0]    last_grant;
  logic [NUM_MASTERS-1:0] req;
  logic             owned;
  logic             g_write;
  logic             g_read;
  logic             read_blocked;
  logic             accept;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [GW-1:0]    fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // First requester after 'last' in circular order; descending scan lets the nearest win.
  function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] last,
                                            input logic [NUM_MASTERS-1:0] r);
    int idx;
    rr_pick = last;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_MASTERS;
      if (r[idx]) rr_pick = GW'(idx);
    end
  endfunction

  assign req          = m_read | m_write;
  assign owned        = (state == ARB_OWNED);
  assign g_write      = m_write[grant];
  assign g_read       = m_read[grant] & ~g_write;
  assign read_blocked = owned & g_read & fifo_full;
  assign accept       = owned & (g_write | (g_read & ~fifo_full)) & ~sdram_waitrequest;
  assign fifo_push    = accept & g_read;
  assign fifo_pop     = sdram_readdatavalid & ~fifo_empty;

  always_comb begin
    m_waitrequest   = '1;
    sdram_address   = '0;
    sdram_writedata = '0;
    sdram_read      = 1'b0;
    sdram_write     = 1'b0;
    if (owned) begin
      sdram_address        = m_address[grant];
      sdram_writedata      = m_writedata[grant];
      sdram_write          = g_write;
      sdram_read           = g_read & ~fifo_full;
      m_waitrequest[grant] = sdram_waitrequest | read_blocked;
    end
  end

  assign m_readdata      = sdram_readdata;
  assign m_readdatavalid = fifo_pop ? (NUM_MASTERS'(1) << fifo_head) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
      err_orphan <= 1'b0;
    end else begin
      if (sdram_readdatavalid && fifo_count == '0) err_orphan <= 1'b1;
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            grant <= rr_pick(last_grant, req);
            state <= ARB_OWNED;
          end
        end
        ARB_OWNED: begin
          if (accept) begin
            last_grant <= grant;
            state      <= ARB_IDLE;
          end else if (!(g_write || g_read)) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  owner_fifo #(
    .DEPTH(MAX_PENDING),
    .WIDTH(GW)
  ) u_owner_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (grant),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_sdram_master_arbiter.sv
// Directed bench for sdram_master_arbiter with two requesters and a 4-deep owner FIFO.
module tb_sdram_master_arbiter;

  logic              clk;
  logic              rst_n;
  logic [1:0][31:0]  m_address;
  logic [1:0]        m_read;
  logic [1:0]        m_write;
  logic [1:0][31:0]  m_writedata;
  logic [1:0]        m_waitrequest;
  logic [31:0]       m_readdata;
  logic [1:0]        m_readdatavalid;
  logic              sdram_waitrequest;
  logic [31:0]       sdram_address;
  logic              sdram_read;
  logic              sdram_write;
  logic [31:0]       sdram_writedata;
  logic [31:0]       sdram_readdata;
  logic              sdram_readdatavalid;
  logic              err_orphan;

  int checks = 0;
  int errors = 0;

  sdram_master_arbiter #(
    .NUM_MASTERS(2),
    .MAX_PENDING(4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .m_address           (m_address),
    .m_read              (m_read),
    .m_write             (m_write),
    .m_writedata         (m_writedata),
    .m_waitrequest       (m_waitrequest),
    .m_readdata          (m_readdata),
    .m_readdatavalid     (m_readdatavalid),
    .sdram_waitrequest   (sdram_waitrequest),
    .sdram_address       (sdram_address),
    .sdram_read          (sdram_read),
    .sdram_write         (sdram_write),
    .sdram_writedata     (sdram_writedata),
    .sdram_readdata      (sdram_readdata),
    .sdram_readdatavalid (sdram_readdatavalid),
    .err_orphan          (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    m_address = '0; m_read = '0; m_write = '0; m_writedata = '0;
    sdram_waitrequest = 1'b0; sdram_readdata = '0; sdram_readdatavalid = 1'b0;
    tick(); tick();
    #1;
    chk("rst_waitreq", 32'(m_waitrequest), 32'h3);
    chk("rst_rdv", 32'(m_readdatavalid), 32'h0);
    chk("rst_sdram_rw", {30'b0, sdram_read, sdram_write}, 32'h0);
    chk("rst_sdram_addr", sdram_address, 32'h0);
    chk("rst_orphan", 32'(err_orphan), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single write from master 1
    m_address[1] = 32'h0000_0040; m_writedata[1] = 32'hDEAD_BEEF; m_write[1] = 1'b1;
    #1;
    chk("wr_idle_nofwd", 32'(sdram_write), 32'h0);
    tick();
    chk("wr_fwd_write", 32'(sdram_write), 32'h1);
    chk("wr_fwd_addr", sdram_address, 32'h0000_0040);
    chk("wr_fwd_data", sdram_writedata, 32'hDEAD_BEEF);
    chk("wr_waitreq", 32'(m_waitrequest), 32'h1);
    tick();
    m_write[1] = 1'b0;
    #1;
    chk("wr_done_write", 32'(sdram_write), 32'h0);
    chk("wr_done_waitreq", 32'(m_waitrequest), 32'h3);

    // Contention: both masters read continuously, grants alternate 0,1,0,1
    m_address[0] = 32'h100; m_address[1] = 32'h200; m_read = 2'b11;
    tick();
    chk("rr0_addr", sdram_address, 32'h100);
    chk("rr0_waitreq", 32'(m_waitrequest), 32'h2);
    chk("rr0_read", 32'(sdram_read), 32'h1);
    tick();
    chk("rr_bubble_read", 32'(sdram_read), 32'h0);
    tick();
    chk("rr1_addr", sdram_address, 32'h200);
    chk("rr1_waitreq", 32'(m_waitrequest), 32'h1);
    tick(); tick();
    chk("rr2_addr", sdram_address, 32'h100);
    tick(); tick();
    chk("rr3_addr", sdram_address, 32'h200);
    tick();
    m_read = 2'b00;
    sdram_readdatavalid = 1'b1; sdram_readdata = 32'h11;
    #1;
    chk("ret11_data", m_readdata, 32'h11);
    chk("ret11_rdv", 32'(m_readdatavalid), 32'h1);
    tick();
    sdram_readdata = 32'h22; #1;
    chk("ret22_rdv", 32'(m_readdatavalid), 32'h2);
    tick();
    sdram_readdata = 32'h33; #1;
    chk("ret33_rdv", 32'(m_readdatavalid), 32'h1);
    tick();
    sdram_readdata = 32'h44; #1;
    chk("ret44_rdv", 32'(m_readdatavalid), 32'h2);
    tick();
    sdram_readdatavalid = 1'b0; #1;
    chk("ret_end_rdv", 32'(m_readdatavalid), 32'h0);
    chk("ret_end_orphan", 32'(err_orphan), 32'h0);

    // FIFO full: fifth read from master 0 is held until a return frees a slot
    m_address[0] = 32'h300; m_read[0] = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    tick();
    chk("full_waitreq", 32'(m_waitrequest), 32'h3);
    chk("full_read", 32'(sdram_read), 32'h0);
    tick();
    chk("full_hold_waitreq", 32'(m_waitrequest), 32'h3);
    sdram_readdatavalid = 1'b1; sdram_readdata = 32'h55;
    #1;
    chk("full_pop_rdv", 32'(m_readdatavalid), 32'h1);
    chk("full_pop_still_held", 32'(sdram_read), 32'h0);
    tick();
    sdram_readdatavalid = 1'b0; #1;
    chk("full_release_read", 32'(sdram_read), 32'h1);
    chk("full_release_waitreq", 32'(m_waitrequest), 32'h2);
    tick();
    m_read[0] = 1'b0;
    sdram_readdatavalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_rdv", 32'(m_readdatavalid), 32'h1);
      tick();
    end
    sdram_readdatavalid = 1'b0;
    #1;
    chk("drain_orphan", 32'(err_orphan), 32'h0);

    // SDRAM stall during a granted write from master 1, master 0 also requesting
    m_address[1] = 32'h80; m_writedata[1] = 32'h1234; m_write[1] = 1'b1;
    m_read[0] = 1'b1; sdram_waitrequest = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_waitreq", 32'(m_waitrequest), 32'h3);
      chk("stall_addr", sdram_address, 32'h80);
      tick();
    end
    sdram_waitrequest = 1'b0; #1;
    chk("stall_accept_waitreq", 32'(m_waitrequest), 32'h1);
    chk("stall_accept_write", 32'(sdram_write), 32'h1);
    tick();
    m_write[1] = 1'b0; m_read[0] = 1'b0; #1;
    chk("stall_done_write", 32'(sdram_write), 32'h0);

    // Orphan return, then reset with two reads pending
    sdram_readdatavalid = 1'b1; sdram_readdata = 32'h99; #1;
    chk("orphan_rdv", 32'(m_readdatavalid), 32'h0);
    tick();
    sdram_readdatavalid = 1'b0; #1;
    chk("orphan_flag", 32'(err_orphan), 32'h1);
    m_read[0] = 1'b1;
    tick(); tick(); tick(); tick();
    m_read[0] = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rst2_orphan", 32'(err_orphan), 32'h0);
    chk("rst2_waitreq", 32'(m_waitrequest), 32'h3);
    chk("rst2_sdram_rw", {30'b0, sdram_read, sdram_write}, 32'h0);
    chk("rst2_sdram_addr", sdram_address, 32'h0);
    rst_n = 1'b1;
    sdram_readdatavalid = 1'b1; #1;
    chk("rst2_fifo_empty_rdv", 32'(m_readdatavalid), 32'h0);
    tick();
    sdram_readdatavalid = 1'b0; #1;
    chk("rst2_late_orphan", 32'(err_orphan), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
